// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the slave-side I2C byte engines.
//   - state_t          : byte transmitter FSM encoding (also exported on the debug port)
//   - SDA_RELEASE      : open-drain level that lets the bus float high
//   - SDA_DRIVE_LOW    : open-drain level that pulls the bus low
//   - DEFAULT_HOLD_CYCLES / DEFAULT_DATA_WIDTH : parameter defaults
package i2c_pkg;

  localparam logic [2:0] ST_IDLE_ENC     = 3'd0;
  localparam logic [2:0] ST_SETUP_ENC    = 3'd1;
  localparam logic [2:0] ST_LOW_ENC      = 3'd2;
  localparam logic [2:0] ST_HIGH_ENC     = 3'd3;
  localparam logic [2:0] ST_ACK_REL_ENC  = 3'd4;
  localparam logic [2:0] ST_ACK_LOW_ENC  = 3'd5;
  localparam logic [2:0] ST_ACK_HIGH_ENC = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE     = ST_IDLE_ENC,
    ST_SETUP    = ST_SETUP_ENC,
    ST_LOW      = ST_LOW_ENC,
    ST_HIGH     = ST_HIGH_ENC,
    ST_ACK_REL  = ST_ACK_REL_ENC,
    ST_ACK_LOW  = ST_ACK_LOW_ENC,
    ST_ACK_HIGH = ST_ACK_HIGH_ENC
  } state_t;

  localparam logic SDA_RELEASE   = 1'b1;
  localparam logic SDA_DRIVE_LOW = 1'b0;

  localparam int DEFAULT_HOLD_CYCLES = 2;
  localparam int DEFAULT_DATA_WIDTH  = 8;

endpackage

// File: rtl/i2c_scl_edge_detect.sv
// i2c_scl_edge_detect: registers the synchronised SCL and produces
// single-cycle rise/fall pulses. Shared by the slave transmitter and receiver.
// Ports:
//   clock, reset_n : system clock, async active-low reset
//   i_scl          : synchronised SCL
//   o_scl_rise     : 1 for one cycle when SCL goes 0 -> 1
//   o_scl_fall     : 1 for one cycle when SCL goes 1 -> 0
module i2c_scl_edge_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic i_scl,
  output logic o_scl_rise,
  output logic o_scl_fall
);

  logic r_scl_last;

  // Idle bus is high, so resetting to 1 avoids a phantom rising edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_scl_last <= 1'b1;
    end else begin
      r_scl_last <= i_scl;
    end
  end

  assign o_scl_rise = ~r_scl_last & i_scl;
  assign o_scl_fall = r_scl_last & ~i_scl;

endmodule

// File: rtl/i2c_slave_write_byte.sv
// i2c_slave_write_byte: slave-side byte transmitter for I2C read transfers.
// Shifts DATA_WIDTH bits onto SDA MSB-first (changing SDA only while SCL is
// low, HOLD_CYCLES after each SCL fall), releases SDA for the ACK bit and
// reports the master's ACK/NACK. Any SDA disagreement while SCL is high
// aborts the byte with a sticky error.
//
// Handshake: i_enable is a one-cycle start pulse, accepted only in IDLE
// with SCL low; i_data is captured on that cycle. o_finish pulses for one
// cycle after the ACK bit's SCL fall; o_ack is valid from that cycle on.
// An aborted byte returns to IDLE with o_error set and no o_finish.
//
// Ports:
//   clock, reset_n : system clock, async active-low reset
//   i_enable       : start pulse
//   i_data         : byte to send
//   i_scl, i_sda   : synchronised bus lines
//   o_sda_out      : open-drain drive (0 pulls low, 1 releases)
//   o_ack          : 1 = master ACKed, 0 = NACK
//   o_error        : bus error / collision, sticky until next accepted start
//   o_finish       : end-of-byte pulse
//   o_state        : debug view of the FSM state
module i2c_slave_write_byte
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  i_enable,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_scl,
  input  logic                  i_sda,
  output logic                  o_sda_out,
  output logic                  o_ack,
  output logic                  o_error,
  output logic                  o_finish,
  output logic [2:0]            o_state
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH);
  localparam logic [3:0]       HOLD_LOAD = 4'(HOLD_CYCLES);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [3:0]            r_hold_cnt;
  logic                  r_sda_out;
  logic                  r_ack;
  logic                  r_ack_sample;
  logic                  r_error;
  logic                  r_finish;

  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic [CNT_W-1:0]      w_bit_cnt_nxt;
  logic [CNT_W-1:0]      w_bit_cnt_inc;
  logic [3:0]            w_hold_cnt_nxt;
  logic                  w_sda_out_nxt;
  logic                  w_ack_nxt;
  logic                  w_ack_sample_nxt;
  logic                  w_error_nxt;
  logic                  w_finish_nxt;
  logic                  w_hold_done;
  logic                  w_scl_rise;
  logic                  w_scl_fall;

  i2c_scl_edge_detect u_scl_edge (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_scl      (i_scl),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall)
  );

  assign w_bit_cnt_inc = r_bit_cnt + 1'b1;
  // The load cycle itself counts as one hold cycle, so the last decrement
  // happens when the counter still reads 1.
  assign w_hold_done   = (r_hold_cnt <= 4'd1);

  always_comb begin
    w_state_nxt      = r_state;
    w_shift_nxt      = r_shift;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_hold_cnt_nxt   = r_hold_cnt;
    w_sda_out_nxt    = r_sda_out;
    w_ack_nxt        = r_ack;
    w_ack_sample_nxt = r_ack_sample;
    w_error_nxt      = r_error;
    w_finish_nxt     = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (i_enable && !i_scl) begin
          w_shift_nxt    = i_data;
          w_bit_cnt_nxt  = '0;
          w_error_nxt    = 1'b0;
          w_hold_cnt_nxt = HOLD_LOAD;
          w_state_nxt    = ST_SETUP;
        end
      end

      ST_SETUP: begin
        w_hold_cnt_nxt = r_hold_cnt - 4'd1;
        if (w_hold_done) begin
          w_hold_cnt_nxt = '0;
          w_sda_out_nxt  = r_shift[DATA_WIDTH-1];
          w_state_nxt    = ST_LOW;
        end
      end

      ST_LOW: begin
        if (w_scl_rise) begin
          w_state_nxt = ST_HIGH;
        end
      end

      ST_HIGH: begin
        // Collision or START/STOP beats the falling-edge advance.
        if (i_sda != r_sda_out) begin
          w_error_nxt   = 1'b1;
          w_sda_out_nxt = SDA_RELEASE;
          w_state_nxt   = ST_IDLE;
        end else if (w_scl_fall) begin
          w_bit_cnt_nxt  = w_bit_cnt_inc;
          w_shift_nxt    = {r_shift[DATA_WIDTH-2:0], 1'b0};
          w_hold_cnt_nxt = HOLD_LOAD;
          w_state_nxt    = (w_bit_cnt_inc == LAST_BIT) ? ST_ACK_REL : ST_SETUP;
        end
      end

      ST_ACK_REL: begin
        w_hold_cnt_nxt = r_hold_cnt - 4'd1;
        if (w_hold_done) begin
          w_hold_cnt_nxt = '0;
          w_sda_out_nxt  = SDA_RELEASE;
          w_state_nxt    = ST_ACK_LOW;
        end
      end

      ST_ACK_LOW: begin
        if (w_scl_rise) begin
          w_ack_sample_nxt = i_sda;
          w_state_nxt      = ST_ACK_HIGH;
        end
      end

      ST_ACK_HIGH: begin
        if (i_sda != r_ack_sample) begin
          w_error_nxt = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_scl_fall) begin
          w_ack_nxt    = ~r_ack_sample;
          w_finish_nxt = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end

      default: begin
        w_sda_out_nxt = SDA_RELEASE;
        w_state_nxt   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_hold_cnt   <= '0;
      r_sda_out    <= SDA_RELEASE;
      r_ack        <= 1'b0;
      r_ack_sample <= 1'b0;
      r_error      <= 1'b0;
      r_finish     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_hold_cnt   <= w_hold_cnt_nxt;
      r_sda_out    <= w_sda_out_nxt;
      r_ack        <= w_ack_nxt;
      r_ack_sample <= w_ack_sample_nxt;
      r_error      <= w_error_nxt;
      r_finish     <= w_finish_nxt;
    end
  end

  assign o_sda_out = r_sda_out;
  assign o_ack     = r_ack;
  assign o_error   = r_error;
  assign o_finish  = r_finish;
  assign o_state   = r_state;

endmodule

// File: tb/tb_i2c_slave_write_byte.sv
// tb_i2c_slave_write_byte: directed bench for the slave byte transmitter.
// A bench-side master drives SCL (8 clocks low / 8 high) and wire-ANDs its
// own SDA drive with the DUT's open-drain output.
module tb_i2c_slave_write_byte;
  import i2c_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       i_enable;
  logic [7:0] i_data;
  logic       i_scl;
  logic       m_sda;
  logic       w_sda;
  logic       o_sda_out;
  logic       o_ack;
  logic       o_error;
  logic       o_finish;
  logic [2:0] o_state;

  always #5 clock = ~clock;

  assign w_sda = o_sda_out & m_sda;

  i2c_slave_write_byte #(.DATA_WIDTH(8), .HOLD_CYCLES(2)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_enable  (i_enable),
    .i_data    (i_data),
    .i_scl     (i_scl),
    .i_sda     (w_sda),
    .o_sda_out (o_sda_out),
    .o_ack     (o_ack),
    .o_error   (o_error),
    .o_finish  (o_finish),
    .o_state   (o_state)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Observations gathered during a transfer.
  int         fin_cnt;
  int         high_chg;
  logic       fin_ack;
  logic       fin_first;
  logic       prev_sda;
  logic [7:0] got;
  logic [7:0] at2;
  logic [7:0] at3;
  logic       err_after_start;
  logic       err_after_ev;
  logic       sda_after_ev;
  logic [2:0] state_after_ev;
  logic       rst_sda, rst_ack, rst_err, rst_fin;
  logic [2:0] rst_state;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (o_finish) begin
      fin_cnt++;
      fin_ack = o_ack;
    end
    if (i_scl && (o_sda_out !== prev_sda)) high_chg++;
    prev_sda = o_sda_out;
  endtask

  // One full byte + ACK from the master's side.
  //   mack    : master pulls SDA low in the 9th pulse
  //   force_p : pulse index where master pulls SDA low mid-high (-1 none)
  //   stop    : master releases SDA mid-high of the ACK pulse
  //   rst_p   : pulse index where reset is asserted mid-high (-1 none)
  //   glitch  : stray enables during pulse 1 (high) and pulse 4 (low)
  task automatic xfer(input logic [7:0] d, input logic mack, input int force_p,
                      input logic stop, input int rst_p, input logic glitch);
    fin_cnt = 0; high_chg = 0; got = '0; at2 = '0; at3 = '0; fin_first = 1'b0;
    prev_sda = o_sda_out;
    m_sda = 1'b1; i_scl = 1'b0; i_data = d; i_enable = 1'b1;
    tick();
    i_enable = 1'b0;
    err_after_start = o_error;
    for (int p = 0; p < 9; p++) begin
      for (int l = 0; l < 8; l++) begin
        if (glitch && p == 4 && l == 5) begin i_data = 8'h00; i_enable = 1'b1; end
        tick();
        i_enable = 1'b0;
        if (l == 0) m_sda = 1'b1;
        if (p >= 1 && p <= 7 && l == 1) at2[8-p] = o_sda_out;
        if (p >= 1 && p <= 7 && l == 2) at3[7-p] = o_sda_out;
      end
      if (p == 8 && mack) m_sda = 1'b0;
      i_scl = 1'b1;
      for (int h = 0; h < 8; h++) begin
        if (force_p == p && h == 2) m_sda = 1'b0;
        if (stop && p == 8 && h == 3) m_sda = 1'b1;
        if (glitch && p == 1 && h == 1) begin i_data = 8'h00; i_enable = 1'b1; end
        if (rst_p == p && h == 2) begin
          reset_n = 1'b0;
          #1;
          rst_sda = o_sda_out; rst_ack = o_ack; rst_err = o_error;
          rst_fin = o_finish; rst_state = o_state;
          tick();
          reset_n = 1'b1; i_scl = 1'b0; m_sda = 1'b1;
          tick();
          return;
        end
        tick();
        i_enable = 1'b0;
        if (h == 0 && p < 8) got[7-p] = o_sda_out;
        if ((force_p == p && h == 2) || (stop && p == 8 && h == 3)) begin
          err_after_ev = o_error; sda_after_ev = o_sda_out; state_after_ev = o_state;
        end
      end
      i_scl = 1'b0;
    end
    tick();
    fin_first = o_finish;
    m_sda = 1'b1;
    repeat (6) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; i_enable = 1'b0; i_data = 8'h00; i_scl = 1'b0; m_sda = 1'b1;
    fin_cnt = 0; high_chg = 0; prev_sda = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_sda_out", 16'(o_sda_out), 16'h1);
    check("rst_ack",     16'(o_ack),     16'h0);
    check("rst_error",   16'(o_error),   16'h0);
    check("rst_finish",  16'(o_finish),  16'h0);
    check("rst_state",   16'(o_state),   16'(ST_IDLE));
    reset_n = 1'b1;
    tick();

    // 0xA5, master ACKs
    xfer(8'hA5, 1'b1, -1, 1'b0, -1, 1'b0);
    check("a5_bits",      16'(got),       16'hA5);
    check("a5_pre_hold",  16'(at2),       16'hA4);
    check("a5_post_hold", 16'(at3),       16'h25);
    check("a5_high_chg",  16'(high_chg),  16'h0);
    check("a5_fin_cnt",   16'(fin_cnt),   16'h1);
    check("a5_fin_lat",   16'(fin_first), 16'h1);
    check("a5_fin_ack",   16'(fin_ack),   16'h1);
    check("a5_error",     16'(o_error),   16'h0);
    check("a5_sda_rel",   16'(o_sda_out), 16'h1);
    check("a5_state",     16'(o_state),   16'(ST_IDLE));

    // Reset while bit 5 (a 0) is driven
    xfer(8'hE0, 1'b1, -1, 1'b0, 4, 1'b0);
    check("mid_rst_sda",   16'(rst_sda),   16'h1);
    check("mid_rst_ack",   16'(rst_ack),   16'h0);
    check("mid_rst_err",   16'(rst_err),   16'h0);
    check("mid_rst_fin",   16'(rst_fin),   16'h0);
    check("mid_rst_state", 16'(rst_state), 16'(ST_IDLE));
    check("mid_rst_nofin", 16'(fin_cnt),   16'h0);

    xfer(8'h81, 1'b1, -1, 1'b0, -1, 1'b0);
    check("x81_bits",    16'(got),      16'h81);
    check("x81_fin_cnt", 16'(fin_cnt),  16'h1);
    check("x81_ack",     16'(o_ack),    16'h1);
    check("x81_hchg",    16'(high_chg), 16'h0);

    // 0x3C, master NACKs
    xfer(8'h3C, 1'b0, -1, 1'b0, -1, 1'b0);
    check("x3c_bits",    16'(got),       16'h3C);
    check("x3c_fin_cnt", 16'(fin_cnt),   16'h1);
    check("x3c_fin_lat", 16'(fin_first), 16'h1);
    check("x3c_ack",     16'(o_ack),     16'h0);
    check("x3c_error",   16'(o_error),   16'h0);
    check("x3c_sda_rel", 16'(o_sda_out), 16'h1);

    // Enable while SCL high is ignored
    i_scl = 1'b1; tick();
    i_data = 8'h12; i_enable = 1'b1; tick();
    i_enable = 1'b0; tick();
    check("en_hi_state", 16'(o_state),   16'(ST_IDLE));
    check("en_hi_sda",   16'(o_sda_out), 16'h1);
    i_scl = 1'b0; tick(); tick();
    check("en_hi_late",  16'(o_state),   16'(ST_IDLE));

    // Stray enables mid-byte, master NACKs
    xfer(8'h96, 1'b0, -1, 1'b0, -1, 1'b1);
    check("x96_bits",    16'(got),      16'h96);
    check("x96_fin_cnt", 16'(fin_cnt),  16'h1);
    check("x96_ack",     16'(o_ack),    16'h0);
    check("x96_hchg",    16'(high_chg), 16'h0);

    // 0xFF, collision during the 3rd SCL high
    xfer(8'hFF, 1'b1, 2, 1'b0, -1, 1'b0);
    check("xff_err_next", 16'(err_after_ev),   16'h1);
    check("xff_sda_rel",  16'(sda_after_ev),   16'h1);
    check("xff_state",    16'(state_after_ev), 16'(ST_IDLE));
    check("xff_nofin",    16'(fin_cnt),        16'h0);
    check("xff_err_hold", 16'(o_error),        16'h1);

    // 0x00, STOP during the ACK high
    xfer(8'h00, 1'b1, -1, 1'b1, -1, 1'b0);
    check("stop_err_clr", 16'(err_after_start), 16'h0);
    check("stop_bits",    16'(got),             16'h00);
    check("stop_err",     16'(err_after_ev),    16'h1);
    check("stop_state",   16'(state_after_ev),  16'(ST_IDLE));
    check("stop_nofin",   16'(fin_cnt),         16'h0);
    check("stop_ack_keep", 16'(o_ack),          16'h0);
    check("stop_sda_rel", 16'(o_sda_out),       16'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
